// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the pipelined ALU.
//   opcode_e  - 4-bit operation codes presented on `control`; 9..15 are illegal
//   state_e   - control FSM states (IDLE: output register empty,
//               MULT: multiplier iterating, HOLD: result presented)
//   mul_iters - number of multiplier iterations for a given width/step size
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_MUL = 4'd2,
    OP_AND = 4'd3,
    OP_OR  = 4'd4,
    OP_XOR = 4'd5,
    OP_SLT = 4'd6,
    OP_SLL = 4'd7,
    OP_SRL = 4'd8
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MULT = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  function automatic int mul_iters(input int width, input int mul_bits);
    return width / mul_bits;
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: iterative unsigned shift-add multiplier.
//   Retires MUL_BITS multiplier bits per cycle. The cycle that sees `start`
//   already performs the first step, so `prod` is final WIDTH/MUL_BITS - 1
//   cycles after the start edge, and `done` is high from then on until the
//   next start.
// Ports:
//   clk, rst_n  clock / async active-low reset (abandons any multiply)
//   start       load a/b and begin a new multiply
//   a, b        unsigned operands (sampled only with start)
//   done        product complete (meaningful after a start)
//   prod        full 2*WIDTH-bit product
module alu_mul_iter #(
  parameter int WIDTH    = 32,
  parameter int MUL_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done,
  output logic [2*WIDTH-1:0]   prod
);
  import alu_pkg::*;

  localparam int ITERS = mul_iters(WIDTH, MUL_BITS);
  localparam int CNT_W = (ITERS > 1) ? $clog2(ITERS) : 1;

  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [CNT_W-1:0]   cnt_q;

  // Sum of the MUL_BITS partial products selected by `bits`.
  function automatic logic [2*WIDTH-1:0] partial(input logic [2*WIDTH-1:0] mcand,
                                                 input logic [MUL_BITS-1:0] bits);
    logic [2*WIDTH-1:0] sum;
    sum = '0;
    for (int j = 0; j < MUL_BITS; j++) begin
      if (bits[j]) sum = sum + (mcand << j);
    end
    return sum;
  endfunction

  logic [2*WIDTH-1:0] a_ext;
  assign a_ext = {{WIDTH{1'b0}}, a};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else if (start) begin
      // First step is folded into the load cycle to meet the overall latency.
      acc_q    <= partial(a_ext, b[MUL_BITS-1:0]);
      mcand_q  <= a_ext << MUL_BITS;
      mplier_q <= b >> MUL_BITS;
      cnt_q    <= CNT_W'(ITERS - 1);
    end else if (cnt_q != '0) begin
      acc_q    <= acc_q + partial(mcand_q, mplier_q[MUL_BITS-1:0]);
      mcand_q  <= mcand_q << MUL_BITS;
      mplier_q <= mplier_q >> MUL_BITS;
      cnt_q    <= cnt_q - 1'b1;
    end
  end

  assign done = (cnt_q == '0);
  assign prod = acc_q;

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: handshaked ALU between operand fetch and writeback.
//   Single-cycle ops (ADD/SUB/AND/OR/XOR/SLT/SLL/SRL, illegal) complete in
//   one cycle; MUL runs on alu_mul_iter. One registered output slot, held
//   under back-pressure; a new op may be accepted on the edge that drains it.
// Ports:
//   clk, rst_n           clock / async active-low reset
//   in_valid, in_ready   upstream handshake; control/oper1/oper2 sampled at accept
//   out_valid, out_ready downstream handshake
//   result, overflow, zero, illegal  registered result and flags
//   busy                 multiply in progress
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int MUL_BITS = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       control,
  input  logic [WIDTH-1:0] oper1,
  input  logic [WIDTH-1:0] oper2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             zero,
  output logic             illegal,
  output logic             busy
);

  localparam int SHW = $clog2(WIDTH);

  state_e state_q, state_d;

  logic             accept;
  logic             is_mul;
  logic             mul_start;
  logic             mul_done;
  logic [2*WIDTH-1:0] mul_prod;

  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;
  logic             alu_ill;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [SHW-1:0]   shamt;
  opcode_e          op;

  logic [WIDTH-1:0] result_q;
  logic             overflow_q;
  logic             zero_q;
  logic             illegal_q;

  assign op        = opcode_e'(control);
  assign is_mul    = (op == OP_MUL);
  assign accept    = in_valid && in_ready;
  assign mul_start = accept && is_mul;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of evaluation order.
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    // NOTE: defaulting every always_comb output first rules out inferred latches.
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept) state_d = is_mul ? ST_MULT : ST_HOLD;
      ST_MULT: if (mul_done) state_d = ST_HOLD;
      ST_HOLD: begin
        if (out_ready) begin
          if (accept) state_d = is_mul ? ST_MULT : ST_HOLD;
          else        state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // in_ready depends combinationally on out_ready in HOLD so a draining
  // result and a new op can share an edge (one op per cycle).
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state_q)
      ST_IDLE: in_ready = 1'b1;
      ST_MULT: busy     = 1'b1;
      ST_HOLD: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
      end
      default: ;
    endcase
  end

  // ---------------- single-cycle datapath ----------------
  assign sum   = oper1 + oper2;
  assign diff  = oper1 - oper2;
  assign shamt = oper2[SHW-1:0];

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    alu_ill = 1'b0;
    unique case (op)
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (oper1[WIDTH-1] == oper2[WIDTH-1]) && (sum[WIDTH-1] != oper1[WIDTH-1]);
      end
      OP_SUB: begin
        // Subtraction overflows when it behaves like adding ~oper2 with matching signs.
        alu_res = diff;
        alu_ovf = (oper1[WIDTH-1] != oper2[WIDTH-1]) && (diff[WIDTH-1] != oper1[WIDTH-1]);
      end
      OP_MUL: ;  // produced by the iterative multiplier
      OP_AND: alu_res = oper1 & oper2;
      OP_OR:  alu_res = oper1 | oper2;
      OP_XOR: alu_res = oper1 ^ oper2;
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(oper1) < $signed(oper2))};
      OP_SLL: alu_res = oper1 << shamt;
      OP_SRL: alu_res = oper1 >> shamt;
      default: alu_ill = 1'b1;
    endcase
  end

  // ---------------- multiplier ----------------
  alu_mul_iter #(
    .WIDTH    (WIDTH),
    .MUL_BITS (MUL_BITS)
  ) u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .start (mul_start),
    .a     (oper1),
    .b     (oper2),
    .done  (mul_done),
    .prod  (mul_prod)
  );

  // ---------------- output register ----------------
  // Flags are derived from the value being loaded, never from result_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q   <= '0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
      illegal_q  <= 1'b0;
    end else if (accept && !is_mul) begin
      result_q   <= alu_res;
      overflow_q <= alu_ovf;
      zero_q     <= (alu_res == '0);
      illegal_q  <= alu_ill;
    end else if ((state_q == ST_MULT) && mul_done) begin
      result_q   <= mul_prod[WIDTH-1:0];
      overflow_q <= |mul_prod[2*WIDTH-1:WIDTH];
      zero_q     <= (mul_prod[WIDTH-1:0] == '0);
      illegal_q  <= 1'b0;
    end
  end

  assign result   = result_q;
  assign overflow = overflow_q;
  assign zero     = zero_q;
  assign illegal  = illegal_q;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: self-checking bench for alu_pipe (WIDTH=32, MUL_BITS=1).
// Expected values come from a behavioural model written with plain
// 64-bit arithmetic; random traffic is scored through a queue.
module tb_alu_pipe;

  localparam int W = 32;
  localparam int MUL_LAT = 33;
  localparam longint MAXS = (longint'(1) << (W-1)) - 1;
  localparam longint MINS = -(longint'(1) << (W-1));

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   control = '0;
  logic [W-1:0] oper1 = '0;
  logic [W-1:0] oper2 = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic         overflow;
  logic         zero;
  logic         illegal;
  logic         busy;

  int n_cmp = 0;
  int n_bad = 0;

  alu_pipe #(.WIDTH(W), .MUL_BITS(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .control   (control),
    .oper1     (oper1),
    .oper2     (oper2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .overflow  (overflow),
    .zero      (zero),
    .illegal   (illegal),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Reference model: returns {result, overflow, zero, illegal}.
  function automatic logic [W+2:0] model(input logic [3:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    logic [W-1:0]   r;
    logic           ov, il;
    longint         sa, sb, s;
    logic [2*W-1:0] p;
    r = '0; ov = 1'b0; il = 1'b0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      4'd0: begin s = sa + sb; r = W'(s); ov = (s > MAXS) || (s < MINS); end
      4'd1: begin s = sa - sb; r = W'(s); ov = (s > MAXS) || (s < MINS); end
      4'd2: begin p = {{W{1'b0}}, a} * {{W{1'b0}}, b}; r = p[W-1:0]; ov = (p[2*W-1:W] != 0); end
      4'd3: r = a & b;
      4'd4: r = a | b;
      4'd5: r = a ^ b;
      4'd6: r = (sa < sb) ? W'(1) : W'(0);
      4'd7: r = a << b[4:0];
      4'd8: r = a >> b[4:0];
      default: il = 1'b1;
    endcase
    return {r, ov, (r == 0), il};
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return W'($urandom);
    endcase
  endfunction

  // Issue one op with out_ready=1 and wait (bounded) for its result.
  // Inputs are scrambled after the accept edge to show they were captured.
  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output int busy_n, output int rdy_n,
                        output logic [W+2:0] obs);
    @(negedge clk);
    out_ready = 1'b1;
    in_valid = 1'b1; control = op; oper1 = a; oper2 = b;
    #1;
    for (int i = 0; i < 100 && !in_ready; i++) begin
      @(negedge clk); #1;
    end
    @(negedge clk);
    in_valid = 1'b0; control = 4'($urandom); oper1 = W'($urandom); oper2 = W'($urandom);
    lat = 1; busy_n = 0; rdy_n = 0;
    while (!out_valid && lat < 100) begin
      if (busy) busy_n++;
      if (in_ready) rdy_n++;
      @(negedge clk);
      lat++;
    end
    obs = {result, overflow, zero, illegal};
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if ({out_valid, busy, result, overflow, zero, illegal} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h expected 0", {out_valid, busy, result, overflow, zero, illegal});
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
  endtask

  // Runs one single-cycle op and checks latency 1 plus the modelled result.
  task automatic test_single(input string name, input logic [3:0] op,
                             input logic [W-1:0] a, input logic [W-1:0] b);
    int lat, bn, rn;
    logic [W+2:0] obs, exp;
    exp = model(op, a, b);
    run_op(op, a, b, lat, bn, rn, obs);
    n_cmp++;
    if (lat !== 1) begin
      n_bad++;
      $display("FAIL %s_latency: got %0d expected 1", name, lat);
    end
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s_value: got %h expected %h", name, obs, exp);
    end
  endtask

  task automatic test_arith();
    test_single("add_7_5", 4'd0, 32'd7, 32'd5);
    n_cmp++;
    if ({result, zero, overflow} !== {32'd12, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL add_7_5_const: got %h expected %h", {result, zero, overflow}, {32'd12, 2'b00});
    end
    test_single("add_ovf", 4'd0, 32'h7FFF_FFFF, 32'd1);
    n_cmp++;
    if ({result, overflow} !== {32'h8000_0000, 1'b1}) begin
      n_bad++;
      $display("FAIL add_ovf_const: got %h expected %h", {result, overflow}, {32'h8000_0000, 1'b1});
    end
    test_single("sub_zero", 4'd1, 32'd5, 32'd5);
    n_cmp++;
    if ({result, zero} !== {32'd0, 1'b1}) begin
      n_bad++;
      $display("FAIL sub_zero_const: got %h expected %h", {result, zero}, {32'd0, 1'b1});
    end
    test_single("sub_ovf", 4'd1, 32'h8000_0000, 32'd1);
  endtask

  task automatic test_mul(input string name, input logic [W-1:0] a, input logic [W-1:0] b);
    int lat, bn, rn;
    logic [W+2:0] obs, exp;
    exp = model(4'd2, a, b);
    run_op(4'd2, a, b, lat, bn, rn, obs);
    n_cmp++;
    if (lat !== MUL_LAT) begin
      n_bad++;
      $display("FAIL %s_latency: got %0d expected %0d", name, lat, MUL_LAT);
    end
    n_cmp++;
    if (bn !== MUL_LAT - 1 || rn !== 0) begin
      n_bad++;
      $display("FAIL %s_busy: got busy=%0d ready=%0d expected busy=%0d ready=0", name, bn, rn, MUL_LAT - 1);
    end
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s_value: got %h expected %h", name, obs, exp);
    end
  endtask

  task automatic test_back_pressure();
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1; control = 4'd0; oper1 = 32'd1; oper2 = 32'd1;
    @(negedge clk);
    control = 4'd3; oper1 = 32'hF0; oper2 = 32'h3C;  // queued while stalled
    for (int i = 0; i < 5; i++) begin
      #1;
      n_cmp++;
      if ({out_valid, in_ready, result, overflow, zero} !== {1'b1, 1'b0, 32'd2, 2'b00}) begin
        n_bad++;
        $display("FAIL bp_hold_%0d: got %h expected %h", i,
                 {out_valid, in_ready, result, overflow, zero}, {1'b1, 1'b0, 32'd2, 2'b00});
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_release_ready: got %b expected 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++;
    if ({out_valid, result} !== {1'b1, 32'h30}) begin
      n_bad++;
      $display("FAIL bp_next_result: got %h expected %h", {out_valid, result}, {1'b1, 32'h30});
    end
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_no_dup: got out_valid=%b expected 0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]   ops [4];
    logic [W-1:0] as [4];
    logic [W-1:0] bs [4];
    logic [W-1:0] fixed [4];
    logic [W+2:0] exp;
    ops = '{4'd5, 4'd6, 4'd7, 4'd8};
    as  = '{W'($urandom), 32'hFFFF_FFFF, 32'd1, 32'h8000_0000};
    bs  = '{W'($urandom), 32'd1, 32'd31, 32'd31};
    fixed = '{as[0] ^ bs[0], 32'd1, 32'h8000_0000, 32'd1};
    @(negedge clk);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) begin
        in_valid = 1'b1; control = ops[i]; oper1 = as[i]; oper2 = bs[i];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (i > 0) begin
        exp = model(ops[i-1], as[i-1], bs[i-1]);
        n_cmp++;
        if ({out_valid, result, overflow, zero, illegal} !== {1'b1, exp} || result !== fixed[i-1]) begin
          n_bad++;
          $display("FAIL b2b_%0d: got %h expected %h", i - 1,
                   {out_valid, result, overflow, zero, illegal}, {1'b1, exp});
        end
      end
      if (i < 4) begin
        n_cmp++;
        if (in_ready !== 1'b1) begin
          n_bad++;
          $display("FAIL b2b_ready_%0d: got %b expected 1", i, in_ready);
        end
      end
      @(negedge clk);
    end
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_drained: got out_valid=%b expected 0", out_valid);
    end
  endtask

  task automatic test_reset_mid_mul();
    int spurious;
    @(negedge clk);
    out_ready = 1'b1;
    in_valid = 1'b1; control = 4'd2; oper1 = 32'd1000; oper2 = 32'd3;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_mul_busy_before: got %b expected 1", busy);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid, busy, result, overflow, zero, illegal} !== '0) begin
      n_bad++;
      $display("FAIL rst_mul_outputs: got %h expected 0", {out_valid, busy, result, overflow, zero, illegal});
    end
    repeat (10) @(negedge clk);
    rst_n = 1'b1;
    spurious = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) spurious++;
    end
    n_cmp++;
    if (spurious !== 0) begin
      n_bad++;
      $display("FAIL rst_mul_abandoned: got %0d outputs expected 0", spurious);
    end
    test_single("rst_add_2_2", 4'd0, 32'd2, 32'd2);
    n_cmp++;
    if (result !== 32'd4) begin
      n_bad++;
      $display("FAIL rst_add_const: got %h expected 4", result);
    end
  endtask

  task automatic test_illegal();
    test_single("illegal_9", 4'd9, W'($urandom), W'($urandom));
    n_cmp++;
    if ({illegal, zero, overflow, result} !== {3'b110, 32'd0}) begin
      n_bad++;
      $display("FAIL illegal_flags: got %h expected %h", {illegal, zero, overflow, result}, {3'b110, 32'd0});
    end
    test_single("illegal_15", 4'd15, 32'd7, 32'd9);
    test_single("after_illegal", 4'd4, 32'h0F00, 32'h00F0);
    n_cmp++;
    if (illegal !== 1'b0) begin
      n_bad++;
      $display("FAIL illegal_cleared: got %b expected 0", illegal);
    end
  endtask

  task automatic test_random();
    localparam int N = 150;
    logic [W+2:0] q [$];
    logic [W+2:0] exp;
    logic [3:0]   op;
    logic         acc, tk;
    int sent, cyc;
    sent = 0; cyc = 0;
    in_valid = 1'b0;
    @(negedge clk);
    while ((sent < N || q.size() != 0) && cyc < 20000) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (!in_valid && sent < N && $urandom_range(0, 1) == 1) begin
        op = 4'($urandom_range(0, 15));
        if (op == 4'd2 && $urandom_range(0, 3) != 0) op = 4'd0;
        control = op; oper1 = pick(); oper2 = pick(); in_valid = 1'b1;
      end
      #1;
      acc = in_valid && in_ready;
      tk  = out_valid && out_ready;
      if (tk) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_bad++;
          $display("FAIL rnd_spurious: got output %h expected none", {result, overflow, zero, illegal});
        end else begin
          exp = q.pop_front();
          if ({result, overflow, zero, illegal} !== exp) begin
            n_bad++;
            $display("FAIL rnd_value: got %h expected %h", {result, overflow, zero, illegal}, exp);
          end
        end
      end
      @(negedge clk);
      cyc++;
      if (acc) begin
        q.push_back(model(control, oper1, oper2));
        in_valid = 1'b0;
        sent++;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    n_cmp++;
    if (sent != N || q.size() != 0) begin
      n_bad++;
      $display("FAIL rnd_complete: got sent=%0d pending=%0d expected sent=%0d pending=0", sent, q.size(), N);
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_mul("mul_2p16", 32'h0001_0000, 32'h0001_0000);
    n_cmp++;
    if ({result, zero, overflow} !== {32'd0, 1'b1, 1'b1}) begin
      n_bad++;
      $display("FAIL mul_2p16_const: got %h expected %h", {result, zero, overflow}, {32'd0, 2'b11});
    end
    test_mul("mul_123_456", 32'd123, 32'd456);
    n_cmp++;
    if ({result, overflow} !== {32'd56088, 1'b0}) begin
      n_bad++;
      $display("FAIL mul_123_456_const: got %h expected %h", {result, overflow}, {32'd56088, 1'b0});
    end
    test_mul("mul_rand", W'($urandom), W'($urandom));
    test_back_pressure();
    test_back_to_back();
    test_reset_mid_mul();
    test_illegal();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
